// File: rtl/conversor_bcd_if.sv
// Start/Ready handshake bundle between the multiplier side and conversor_bcd.
// The Signo wire exists only when BCD_SIGNO_EN is defined.
interface conversor_bcd_if #(
  parameter int N_BITS    = 17,
  parameter int N_DIGITOS = 6
);
  logic                   Start;
  logic [N_BITS-1:0]      Binario;
  logic                   Ready;
  logic                   Ocupado;
  logic [4*N_DIGITOS-1:0] Bcd;
  logic                   Desborde;
`ifdef BCD_SIGNO_EN
  logic                   Signo;
`endif

  modport master (
    output Start, Binario,
    input  Ready, Ocupado, Bcd, Desborde
`ifdef BCD_SIGNO_EN
    , input Signo
`endif
  );

  modport slave (
    input  Start, Binario,
    output Ready, Ocupado, Bcd, Desborde
`ifdef BCD_SIGNO_EN
    , output Signo
`endif
  );
endinterface

// File: rtl/conversor_bcd.sv
// Sequential binary-to-BCD converter (shift-add-3), one bit per clock.
// Define BCD_SIGNO_EN to treat Binario as two's complement and drive Signo.
module conversor_bcd #(
  parameter int N_BITS    = 17,
  parameter int N_DIGITOS = 6
) (
  input  logic            Clock,
  input  logic            Reset,
  conversor_bcd_if.slave  bus
);

  localparam int CW = $clog2(N_BITS + 1);
  localparam int BW = 4 * N_DIGITOS;

  typedef enum logic [1:0] {IDLE, CONVIERTE, LISTO} estado_t;

  estado_t           estado_reg;
  logic [N_BITS-1:0] bin_reg;
  logic [BW-1:0]     bcd_sr_reg;
  logic [CW-1:0]     cnt_reg;
  logic              ovf_reg;
  logic [BW-1:0]     bcd_reg;
  logic              ready_reg;
  logic              ocupado_reg;
  logic              desborde_reg;
  logic [BW-1:0]     bcd_adj;
  logic [N_BITS-1:0] operando;

  // Add-3 correction applied to every digit in parallel before the shift.
  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITOS; gi++) begin : g_ajuste
      assign bcd_adj[4*gi +: 4] = (bcd_sr_reg[4*gi +: 4] >= 4'd5)
                                  ? bcd_sr_reg[4*gi +: 4] + 4'd3
                                  : bcd_sr_reg[4*gi +: 4];
    end
  endgenerate

`ifdef BCD_SIGNO_EN
  logic signo_reg;

  // N_BITS-bit unsigned magnitude: the most negative value maps to 2^(N_BITS-1).
  assign operando = bus.Binario[N_BITS-1] ? ({N_BITS{1'b0}} - bus.Binario)
                                          : bus.Binario;
  assign bus.Signo = signo_reg;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      signo_reg <= 1'b0;
    end else if (bus.Start && (estado_reg != CONVIERTE)) begin
      signo_reg <= bus.Binario[N_BITS-1];
    end
  end
`else
  assign operando = bus.Binario;
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      estado_reg   <= IDLE;
      bin_reg      <= '0;
      bcd_sr_reg   <= '0;
      cnt_reg      <= '0;
      ovf_reg      <= 1'b0;
      bcd_reg      <= '0;
      ready_reg    <= 1'b0;
      ocupado_reg  <= 1'b0;
      desborde_reg <= 1'b0;
    end else begin
      case (estado_reg)
        IDLE, LISTO: begin
          if (bus.Start) begin
            bin_reg     <= operando;
            bcd_sr_reg  <= '0;
            cnt_reg     <= CW'(N_BITS);
            ovf_reg     <= 1'b0;
            ready_reg   <= 1'b0;
            ocupado_reg <= 1'b1;
            estado_reg  <= CONVIERTE;
          end
        end
        CONVIERTE: begin
          if (cnt_reg != '0) begin
            // The top digit's MSB leaves the register here: that is the overflow.
            {bcd_sr_reg, bin_reg} <= {bcd_adj[BW-2:0], bin_reg, 1'b0};
            ovf_reg               <= ovf_reg | bcd_adj[BW-1];
            cnt_reg               <= cnt_reg - CW'(1);
          end else begin
            bcd_reg      <= bcd_sr_reg;
            desborde_reg <= ovf_reg;
            ready_reg    <= 1'b1;
            ocupado_reg  <= 1'b0;
            estado_reg   <= LISTO;
          end
        end
        default: begin
          estado_reg  <= IDLE;
          ready_reg   <= 1'b0;
          ocupado_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Ready    = ready_reg;
  assign bus.Ocupado  = ocupado_reg;
  assign bus.Bcd      = bcd_reg;
  assign bus.Desborde = desborde_reg;

endmodule
